pp_seq_mult: RTL and testbench
==============================

Name: pp_seq_mult

Overview:
- Parametrised, sequential successor to the 4x4 combinational partial-product array.
- Generates PPR AND-gated partial-product rows per clock and accumulates them into a 2*WIDTH-bit product.
- Supports unsigned and two's-complement operands, selected per transaction.
- Valid/ready handshakes on both sides, so it drops directly into datapaths that need a small multiplier where area matters more than throughput.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- PPR, 1, partial-product rows generated and accumulated per cycle; must divide WIDTH exactly (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- X  input  WIDTH  multiplicand
- Y  input  WIDTH  multiplier
- tc  input  1  1 = two's-complement operands, 0 = unsigned; sampled with X/Y
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- P  output  2*WIDTH  product
- busy  output  1  high in RUN or DONE

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, sampled on a rising clk edge, overrides everything:
  - state <= IDLE
  - out_valid <= 0
  - P <= 0
  - internal accumulator, row counter and operand registers <= 0
- in_ready = (state == IDLE) && !rst, combinational. busy = (state != IDLE).
- FSM states:
  - IDLE: on in_valid && in_ready, latch X, Y and tc; clear accumulator; row count <= 0; go to RUN. With no valid input, stay in IDLE.
  - RUN: each cycle, add rows i = cnt .. cnt+PPR-1 into the accumulator, then cnt += PPR. After the last step (cnt reaches WIDTH), go to DONE and register P <= final sum with out_valid <= 1 on the same edge.
  - DONE: hold P and out_valid stable. On out_ready, out_valid <= 0 and go to IDLE. Stay in DONE indefinitely while out_ready = 0.
- Row generation, 2*WIDTH-bit arithmetic, modulo 2^(2*WIDTH):
  - Xe = X zero-extended when tc = 0, sign-extended when tc = 1.
  - row i = (Xe AND replicate(Y[i])) << i.
  - When tc = 1 and i = WIDTH-1, the row is subtracted instead of added.
  - Result is exact for every operand pair in both modes, including the most negative value times itself.
- Latency:
  - Accept edge -> out_valid high after exactly WIDTH/PPR clock edges.
  - Minimum back-to-back issue interval is WIDTH/PPR + 2 cycles (DONE handshake, then IDLE accept).
- No overlap: in_ready = 0 throughout RUN and DONE. in_valid asserted then is ignored and is not queued.
- Operand or tc changes on the inputs after acceptance have no effect.
- Accept and output handshake can never occur in the same cycle.
- Reset asserted mid-RUN or in DONE:
  - the operation is aborted with no product emitted;
  - out_valid = 0 on the edge after rst is sampled high;
  - in_ready = 1 on the first cycle with rst low.
- out_ready asserted while out_valid = 0 has no effect.

Test Plan:
- WIDTH=8, PPR=1, tc=0, X=0xFF, Y=0xFF -> out_valid rises exactly 8 edges after accept, P=0xFE01. With out_ready held high it drops next edge, and in_ready returns.
- WIDTH=8, tc=1:
  - X=0x80, Y=0x80 -> P=0x4000
  - X=0xFF, Y=0x01 -> P=0xFFFF
  - X=0x7F, Y=0x80 -> P=0xC080
  - Same X=0xFF, Y=0x01 with tc=0 -> P=0x00FF
- Backpressure: out_ready held low 5 cycles after out_valid -> P and out_valid stable, in_ready=0. A new in_valid pulse during DONE is not accepted. Releasing out_ready completes the handshake, and the next operand set is accepted one cycle later.
- Reset mid-operation: rst high for 1 cycle at RUN cycle 3 -> out_valid never asserts for that op, P=0. The next op X=3, Y=5 gives P=15.
- WIDTH=4, PPR=4, tc=0, X=0xF, Y=0xF -> P=0xE1 after 1 cycle. With PPR=2 -> same P after 2 cycles.
- Randomised: 2000 random X/Y/tc pairs with random out_ready stalls for WIDTH=8 and PPR in {1,2,4,8}. P is compared against a reference multiply, and every run must show latency exactly WIDTH/PPR.

Source files
------------

// File: rtl/pp_seq_mult.sv
// Sequential shift-and-add multiplier: PPR AND-gated partial-product rows
// per clock, unsigned or two's-complement per transaction, valid/ready both sides.
module pp_seq_mult #(
    parameter int WIDTH = 8,
    parameter int PPR   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    input  logic               tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEP = CW'(PPR);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - PPR);
    localparam logic [CW-1:0] MSB  = CW'(WIDTH - 1);

    if (WIDTH < 2 || PPR < 1 || (WIDTH % PPR) != 0) begin : g_param_check
        $fatal(1, "pp_seq_mult: WIDTH must be >= 2 and divisible by PPR");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             tc_q, tc_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;

    logic [PW-1:0]    xe;
    logic [PW-1:0]    row;
    logic [PW-1:0]    sum;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] ybits;

    assign xe = tc_q ? {{WIDTH{x_q[WIDTH-1]}}, x_q} : {{WIDTH{1'b0}}, x_q};

    // The multiplier MSB carries negative weight in two's-complement mode
    always_comb begin
        sum   = acc_q;
        row   = '0;
        idx   = '0;
        ybits = '0;
        for (int j = 0; j < PPR; j++) begin
            idx   = cnt_q + CW'(j);
            ybits = y_q >> idx;
            row   = (xe & {PW{ybits[0]}}) << idx;
            if (tc_q && idx == MSB) begin
                sum = sum - row;
            end else begin
                sum = sum + row;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        tc_d        = tc_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_d     = X;
                    y_d     = Y;
                    tc_d    = tc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST) begin
                    p_d         = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            tc_q        <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tc_q        <= tc_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_pp_seq_mult.sv
// Bench for pp_seq_mult: directed table and corner sequences on WIDTH=8/PPR=1,
// plus randomised traffic on several WIDTH/PPR configurations.
module tb_pp_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_done = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference product: interpret operands as integers, multiply, wrap.
    function automatic longint ref_mul(input int w, input longint a,
                                       input longint b, input bit t);
        longint av, bv, r;
        av = a;
        bv = b;
        if (t && a >= (longint'(1) << (w - 1))) av = a - (longint'(1) << w);
        if (t && b >= (longint'(1) << (w - 1))) bv = b - (longint'(1) << w);
        r = av * bv;
        return r & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // ---------------- directed instance: WIDTH=8, PPR=1 ----------------
    logic        m_rst, m_iv, m_ir, m_tc, m_ov, m_ordy, m_busy;
    logic [7:0]  m_x, m_y;
    logic [15:0] m_p;

    pp_seq_mult #(.WIDTH(8), .PPR(1)) u_main (
        .clk      (clk),
        .rst      (m_rst),
        .in_valid (m_iv),
        .in_ready (m_ir),
        .X        (m_x),
        .Y        (m_y),
        .tc       (m_tc),
        .out_valid(m_ov),
        .out_ready(m_ordy),
        .P        (m_p),
        .busy     (m_busy)
    );

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        bit          tc;
        logic [15:0] p;
    } vec_t;

    task automatic m_wait_valid(input string nm);
        int lat;
        lat = 0;
        while (!m_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'd8);
    endtask

    task automatic m_op(input logic [7:0] a, input logic [7:0] b,
                        input bit t, input logic [15:0] exp, input string nm);
        check({nm, "_in_ready"}, 64'(m_ir), 64'd1);
        m_x  = a;
        m_y  = b;
        m_tc = t;
        m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        m_x  = ~a;
        m_y  = 8'($urandom);
        m_tc = ~t;
        m_wait_valid(nm);
        check({nm, "_P"}, 64'(m_p), 64'(exp));
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;
        check({nm, "_valid_drop"}, 64'(m_ov), 64'd0);
    endtask

    initial begin
        vec_t vt[10];
        int   guard;
        bit   seen;
        vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vt[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vt[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vt[3] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vt[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vt[5] = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vt[6] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vt[7] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
        vt[8] = '{8'h80, 8'hFF, 1'b1, 16'h0080};
        vt[9] = '{8'h80, 8'h80, 1'b0, 16'h4000};

        m_rst = 1'b1; m_iv = 1'b0; m_x = '0; m_y = '0; m_tc = 1'b0; m_ordy = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(m_ir), 64'd0);
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_P", 64'(m_p), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        m_rst = 1'b0;
        #1;
        check("rst_release_ready", 64'(m_ir), 64'd1);

        for (int i = 0; i < 10; i++) begin
            m_op(vt[i].x, vt[i].y, vt[i].tc, vt[i].p, $sformatf("vec%0d", i));
        end

        // backpressure with a rejected in_valid pulse during DONE
        m_x = 8'hFF; m_y = 8'hFF; m_tc = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        m_wait_valid("bp");
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", 64'(m_ov), 64'd1);
            check("bp_P_hold", 64'(m_p), 64'hFE01);
            check("bp_in_ready", 64'(m_ir), 64'd0);
            m_iv = (c == 2);
            m_x  = 8'd3;
            m_y  = 8'd5;
            @(posedge clk); #1;
        end
        m_iv = 1'b0;
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;
        check("bp_valid_drop", 64'(m_ov), 64'd0);
        check("bp_ready_back", 64'(m_ir), 64'd1);
        m_x = 8'd2; m_y = 8'd7; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        check("bp_next_accept", 64'(m_busy), 64'd1);
        m_wait_valid("bp_next");
        check("bp_next_P", 64'(m_p), 64'd14);
        m_ordy = 1'b1;
        @(posedge clk); #1;
        m_ordy = 1'b0;

        // abort in the middle of RUN
        m_x = 8'h12; m_y = 8'h34; m_tc = 1'b0; m_iv = 1'b1;
        @(posedge clk); #1;
        m_iv = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        m_rst = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", 64'(m_ov), 64'd0);
        check("abort_P", 64'(m_p), 64'd0);
        check("abort_busy", 64'(m_busy), 64'd0);
        check("abort_ready_in_rst", 64'(m_ir), 64'd0);
        m_rst = 1'b0;
        #1;
        check("abort_ready", 64'(m_ir), 64'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= m_ov;
        end
        check("abort_no_product", 64'(seen), 64'd0);
        m_op(8'd3, 8'd5, 1'b0, 16'd15, "after_abort");

        guard = 0;
        while (n_done < 6 && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        check("random_configs_done", 64'(n_done), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- randomised instances over WIDTH/PPR ----------------
    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int W    = (g < 4) ? 8 : 4;
        localparam int R    = (g < 4) ? (1 << g) : ((g == 4) ? 4 : 2);
        localparam int NOPS = (g < 4) ? 450 : 100;

        logic             rst_g, iv, ir, tcv, ov, ordy, bz;
        logic [W-1:0]     x, y;
        logic [2*W-1:0]   p;

        pp_seq_mult #(.WIDTH(W), .PPR(R)) u_dut (
            .clk      (clk),
            .rst      (rst_g),
            .in_valid (iv),
            .in_ready (ir),
            .X        (x),
            .Y        (y),
            .tc       (tcv),
            .out_valid(ov),
            .out_ready(ordy),
            .P        (p),
            .busy     (bz)
        );

        task automatic g_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit t, input int stall);
            int             lat;
            logic [2*W-1:0] exp;
            exp = (2*W)'(ref_mul(W, longint'(a), longint'(b), t));
            check($sformatf("cfg%0d_in_ready", g), 64'(ir), 64'd1);
            x   = a;
            y   = b;
            tcv = t;
            iv  = 1'b1;
            @(posedge clk); #1;
            x   = W'($urandom);
            y   = W'($urandom);
            tcv = 1'($urandom);
            lat = 0;
            while (!ov && lat < 40) begin
                iv   = 1'($urandom);
                ordy = 1'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("cfg%0d_latency", g), 64'(lat), 64'(W / R));
            check($sformatf("cfg%0d_P a=%0h b=%0h tc=%0d", g, a, b, t),
                  64'(p), 64'(exp));
            ordy = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                iv = 1'($urandom);
                check($sformatf("cfg%0d_stall_valid", g), 64'(ov), 64'd1);
                check($sformatf("cfg%0d_stall_P", g), 64'(p), 64'(exp));
            end
            ordy = 1'b1;
            @(posedge clk); #1;
            ordy = 1'b0;
            iv   = 1'b0;
            check($sformatf("cfg%0d_valid_drop", g), 64'(ov), 64'd0);
        endtask

        initial begin
            rst_g = 1'b1; iv = 1'b0; x = '0; y = '0; tcv = 1'b0; ordy = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_g = 1'b0;
            #1;
            check($sformatf("cfg%0d_rst_P", g), 64'(p), 64'd0);
            check($sformatf("cfg%0d_rst_valid", g), 64'(ov), 64'd0);
            g_op('1, '1, 1'b0, 0);
            for (int n = 0; n < NOPS; n++) begin
                g_op(W'($urandom), W'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)));
            end
            n_done++;
        end
    end

endmodule
